// File: rtl/rtc_bus_read.sv
// -----------------------------------------------------------------------------
// rtc_bus_read
// Bus-cycle generator for an Intel-style multiplexed address/data RTC bus.
// A rising request on `activa` runs one address-write cycle (register address
// `dir` driven on the AD bus under wr_n) followed by one data-read cycle
// (byte sampled from the AD bus under rd_n). The byte is returned on `dato`
// together with a single-cycle `fin` pulse.
//
// Optional build macro: RTC_BUS_ABORT_EN
//   When defined, `activa` falling during A_SU..D_H aborts the transaction.
//   An active strobe is first released through a one-cycle hold state, and
//   then the chip select is released. No fin is issued and dato is unchanged.
//   When undefined, `activa` is ignored after the start edge.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   activa  in   read request level from the sequencer
//   dir     in   RTC register address, latched on the start edge
//   ad_in   in   AD bus value returned from the pad tristate
//   ad_out  out  AD bus drive value (latched address)
//   ad_oe   out  AD pad output enable (1 = FPGA drives)
//   cs_n    out  RTC chip select, active low
//   wr_n    out  write strobe, active low
//   rd_n    out  read strobe, active low
//   ad_sel  out  0 = address phase, 1 = data phase
//   dato    out  last byte read, held until the next completed read
//   fin     out  one-cycle pulse: read complete, dato valid
//   busy    out  high from the start edge through DONE
//
// Every output is a register loaded from the decoded next state, so the
// outputs change on the same edge as the state register and nothing is
// combinational from input to output.
// -----------------------------------------------------------------------------
module rtc_bus_read #(
  parameter int DW   = 8,
  parameter int T_SU = 2,
  parameter int T_PW = 4,
  parameter int T_H  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          activa,
  input  logic [DW-1:0] dir,
  input  logic [DW-1:0] ad_in,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n,
  output logic          ad_sel,
  output logic [DW-1:0] dato,
  output logic          fin,
  output logic          busy
);

  // Counter must hold (longest duration - 1).
  localparam int TMAX_A = (T_SU > T_PW) ? T_SU : T_PW;
  localparam int TMAX   = (TMAX_A > T_H) ? TMAX_A : T_H;
  localparam int CW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] C_SU = CW'(T_SU - 1);
  localparam logic [CW-1:0] C_PW = CW'(T_PW - 1);
  localparam logic [CW-1:0] C_H  = CW'(T_H - 1);
  localparam logic [CW-1:0] C_0  = {CW{1'b0}};
  localparam logic [CW-1:0] C_1  = CW'(1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SU     = 4'd1,
    A_WR     = 4'd2,
    A_H      = 4'd3,
    TURN     = 4'd4,
    D_RD     = 4'd5,
    D_H      = 4'd6,
    DONE     = 4'd7,
    WAIT_LOW = 4'd8
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          capture;
  logic          cs_n_nxt, wr_n_nxt, rd_n_nxt, ad_sel_nxt, ad_oe_nxt;
  logic          fin_nxt, busy_nxt;
  logic          start;

`ifdef RTC_BUS_ABORT_EN
  logic abort, abort_nxt;
`endif

  assign start = (state == IDLE) && activa;

  // Next-state, down-counter and read-capture decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (activa) begin
          state_nxt = A_SU;
          cnt_nxt   = C_SU;
        end else begin
          state_nxt = IDLE;
        end
      end
      A_SU: begin
        if (cnt == C_0) begin
          state_nxt = A_WR;
          cnt_nxt   = C_PW;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      A_WR: begin
        if (cnt == C_0) begin
          state_nxt = A_H;
          cnt_nxt   = C_H;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      A_H: begin
        if (cnt == C_0) begin
          state_nxt = TURN;
          cnt_nxt   = C_SU;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      TURN: begin
        if (cnt == C_0) begin
          state_nxt = D_RD;
          cnt_nxt   = C_PW;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      D_RD: begin
        // Sample on the exit edge, while rd_n is still low.
        if (cnt == C_0) begin
          state_nxt = D_H;
          cnt_nxt   = C_H;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      D_H: begin
        if (cnt == C_0) begin
          state_nxt = DONE;
          cnt_nxt   = C_0;
        end else begin
          cnt_nxt = cnt - C_1;
        end
      end
      DONE: begin
        state_nxt = WAIT_LOW;
        cnt_nxt   = C_0;
      end
      WAIT_LOW: begin
        // Holding here until the request drops prevents re-triggering
        // on the same request level.
        if (!activa) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_LOW;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = C_0;
      end
    endcase

`ifdef RTC_BUS_ABORT_EN
    abort_nxt = 1'b0;
    if (abort) begin
      // Strobe has been released for one cycle; now drop cs_n and ad_oe.
      state_nxt = IDLE;
      cnt_nxt   = C_0;
      capture   = 1'b0;
    end else if (!activa && (state >= A_SU) && (state <= D_H)) begin
      capture = 1'b0;
      cnt_nxt = C_0;
      case (state)
        A_WR: begin
          state_nxt = A_H;
          abort_nxt = 1'b1;
        end
        D_RD: begin
          state_nxt = D_H;
          abort_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end else begin
      abort_nxt = 1'b0;
    end
`endif
  end

  // Output decode from the next state, so the output registers track state.
  always_comb begin
    cs_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    rd_n_nxt   = 1'b1;
    ad_sel_nxt = 1'b1;
    ad_oe_nxt  = 1'b0;
    fin_nxt    = 1'b0;
    busy_nxt   = 1'b1;
    case (state_nxt)
      A_SU, A_H: begin
        cs_n_nxt   = 1'b0;
        ad_sel_nxt = 1'b0;
        ad_oe_nxt  = 1'b1;
      end
      A_WR: begin
        cs_n_nxt   = 1'b0;
        ad_sel_nxt = 1'b0;
        ad_oe_nxt  = 1'b1;
        wr_n_nxt   = 1'b0;
      end
      TURN, D_H: begin
        cs_n_nxt = 1'b0;
      end
      D_RD: begin
        cs_n_nxt = 1'b0;
        rd_n_nxt = 1'b0;
      end
      DONE: begin
        fin_nxt = 1'b1;
      end
      IDLE, WAIT_LOW: begin
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= C_0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      rd_n   <= 1'b1;
      ad_sel <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= {DW{1'b0}};
      dato   <= {DW{1'b0}};
      fin    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cs_n   <= cs_n_nxt;
      wr_n   <= wr_n_nxt;
      rd_n   <= rd_n_nxt;
      ad_sel <= ad_sel_nxt;
      ad_oe  <= ad_oe_nxt;
      fin    <= fin_nxt;
      busy   <= busy_nxt;
      // ad_out doubles as the address latch; later dir changes are ignored.
      if (start) begin
        ad_out <= dir;
      end
      if (capture) begin
        dato <= ad_in;
      end
    end
  end

`ifdef RTC_BUS_ABORT_EN
  // Abort-in-progress flag for the one-cycle strobe release.
  always_ff @(posedge clk) begin
    if (reset) begin
      abort <= 1'b0;
    end else begin
      abort <= abort_nxt;
    end
  end
`endif

endmodule
